// File: rtl/tdm_demux_4ch.sv
// Receive side of the 4-channel TDM link: recovers frame alignment from frame_sync
// and deserialises each frame into four parallel W-bit channel words.
// Optional build macro TDM_PARITY_EN adds a fifth even-parity slot and a parity_err output.
module tdm_demux_4ch #(
  parameter int unsigned W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           frame_sync,
  output logic [4*W-1:0] dout,
  output logic           dout_valid,
  output logic           locked,
`ifdef TDM_PARITY_EN
  output logic           parity_err,
`endif
  output logic           sync_err
);

`ifdef TDM_PARITY_EN
  localparam int unsigned NSLOT  = 5;
  localparam int unsigned SLOT_W = 3;
`else
  localparam int unsigned NSLOT  = 4;
  localparam int unsigned SLOT_W = 2;
`endif
  // Slots held before the frame-closing slot (channels 0..2, or 0..3 with parity).
  localparam int unsigned NHOLD  = NSLOT - 1;
  localparam int unsigned HOLD_W = NHOLD * W;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOT - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [4*W-1:0]      dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                sync_err_q, sync_err_d;
  logic                locked_q, locked_d;
  logic [4*W-1:0]      frame_c;
`ifdef TDM_PARITY_EN
  logic                parity_err_q, parity_err_d;
  logic                parity_bad_c;

  // Parity slot closes the frame; even parity means data XOR parity bit must be 0.
  assign frame_c      = hold_q;
  assign parity_bad_c = din[0] ^ (^hold_q);
`else
  assign frame_c      = {din, hold_q};
`endif

  // State, slot counter, holding register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      slot_q       <= '0;
      hold_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      locked_q     <= 1'b0;
`ifdef TDM_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      hold_q       <= hold_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_err_q   <= sync_err_d;
      locked_q     <= locked_d;
`ifdef TDM_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Alignment tracking and frame assembly; only accepted samples change anything.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    hold_d       = hold_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sync_err_d   = 1'b0;
`ifdef TDM_PARITY_EN
    parity_err_d = 1'b0;
`endif
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (frame_sync) begin
            hold_d[W-1:0] = din;
            slot_d        = SLOT_W'(1);
            state_d       = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync && (slot_q != '0)) begin
            // Early sync: drop the partial frame and re-align on this sample.
            sync_err_d    = 1'b1;
            hold_d[W-1:0] = din;
            slot_d        = SLOT_W'(1);
          end else if (!frame_sync && (slot_q == '0)) begin
            sync_err_d = 1'b1;
            slot_d     = '0;
            state_d    = HUNT;
          end else if (slot_q == LAST_SLOT) begin
            dout_d       = frame_c;
            dout_valid_d = 1'b1;
            slot_d       = '0;
`ifdef TDM_PARITY_EN
            parity_err_d = parity_bad_c;
`endif
          end else begin
            for (int i = 0; i < int'(NHOLD); i++) begin
              if (slot_q == SLOT_W'(i)) begin
                hold_d[i*W +: W] = din;
              end
            end
            slot_d = slot_q + SLOT_W'(1);
          end
        end
        default: begin
          state_d = HUNT;
          slot_d  = '0;
        end
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sync_err   = sync_err_q;
  assign locked     = locked_q;
`ifdef TDM_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Self-checking bench for tdm_demux_4ch: expected frames are queued as stimulus is
// driven and compared by a monitor whenever dout_valid pulses.
module tb_tdm_demux_4ch;

  localparam int unsigned W = 1;
`ifdef TDM_PARITY_EN
  localparam int unsigned NSLOT = 5;
`else
  localparam int unsigned NSLOT = 4;
`endif
  localparam int unsigned PERIOD = 10;

  typedef struct packed {
    logic [4*W-1:0] data;
    logic           perr;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   din;
  logic           din_valid;
  logic           frame_sync;
  logic [4*W-1:0] dout;
  logic           dout_valid;
  logic           locked;
  logic           sync_err;
`ifdef TDM_PARITY_EN
  logic           parity_err;
`endif

  int    errors = 0;
  int    checks = 0;
  int    vcnt   = 0;
  int    ecnt   = 0;
  exp_t  exp_q[$];
  time   vtimes[$];
  exp_t  mon_e;

  tdm_demux_4ch #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .locked     (locked),
`ifdef TDM_PARITY_EN
    .parity_err (parity_err),
`endif
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  // Scoreboard monitor: every dout_valid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sync_err) ecnt++;
      if (dout_valid) begin
        vcnt++;
        vtimes.push_back($time);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame: dout=%h with no frame expected at %0t", dout, $time);
        end else begin
          mon_e = exp_q.pop_front();
          if (dout !== mon_e.data) begin
            errors++;
            $display("FAIL frame_data: dout=%h expected %h at %0t", dout, mon_e.data, $time);
          end
`ifdef TDM_PARITY_EN
          checks++;
          if (parity_err !== mon_e.perr) begin
            errors++;
            $display("FAIL parity_err: got %b expected %b at %0t", parity_err, mon_e.perr, $time);
          end
`endif
        end
      end
    end
  end

  task automatic put(input logic [W-1:0] d, input logic s);
    @(negedge clk);
    din        = d;
    frame_sync = s;
    din_valid  = 1'b1;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid  = 1'b0;
      din        = W'($urandom);
      frame_sync = 1'($urandom);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    #1;
  endtask

  // Sends channels start..3 of f (channel 0 carries the sync) plus parity if built in.
  task automatic send_from(input logic [4*W-1:0] f, input int start,
                           input bit gaps, input logic pforce);
    exp_t e;
    e.data = f;
    e.perr = pforce;
    for (int i = start; i < 4; i++) begin
`ifndef TDM_PARITY_EN
      if (i == 3) exp_q.push_back(e);
`endif
      put(f[i*W +: W], (i == 0));
      if (gaps) gap(2);
    end
`ifdef TDM_PARITY_EN
    exp_q.push_back(e);
    put(W'((^f) ^ pforce), 1'b0);
    if (gaps) gap(2);
`endif
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    din        = '0;
    repeat (2) @(negedge clk);
    checks += 4;
    if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %h expected 0", dout); end
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b expected 0", dout_valid); end
    if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
    if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err: got %b expected 0", sync_err); end
    rst_n = 1'b1;
    gap(2);
  endtask

  task automatic test_lock_frame();
    int v0 = vcnt;
    put(1'b1, 1'b1);
    settle();
    checks += 2;
    if (locked !== 1'b1) begin errors++; $display("FAIL lock_after_sync: locked=%b expected 1", locked); end
    if (vcnt != v0) begin errors++; $display("FAIL lock_no_early_frame: frames=%0d expected %0d", vcnt, v0); end
    send_from(4'b1101, 1, 1'b0, 1'b0);
    settle();
    checks += 2;
    if (vcnt != v0 + 1) begin errors++; $display("FAIL lock_frame_count: frames=%0d expected %0d", vcnt, v0 + 1); end
    if (locked !== 1'b1) begin errors++; $display("FAIL lock_stays: locked=%b expected 1", locked); end
  endtask

  task automatic test_valid_gaps();
    int v0 = vcnt;
    send_from(4'b0110, 0, 1'b1, 1'b0);
    gap(3);
    settle();
    checks += 2;
    if (vcnt != v0 + 1) begin errors++; $display("FAIL gaps_frame_count: frames=%0d expected %0d", vcnt, v0 + 1); end
    if (dout !== 4'b0110) begin errors++; $display("FAIL gaps_dout_hold: dout=%h expected 6", dout); end
  endtask

  task automatic test_early_sync();
    int v0 = vcnt;
    int e0 = ecnt;
    put(1'b1, 1'b1);
    put(1'b0, 1'b0);
    put(1'b1, 1'b1);
    settle();
    checks += 3;
    if (sync_err !== 1'b1) begin errors++; $display("FAIL early_sync_err: got %b expected 1", sync_err); end
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL early_no_valid: got %b expected 0", dout_valid); end
    if (locked !== 1'b1) begin errors++; $display("FAIL early_locked: got %b expected 1", locked); end
    send_from(4'b1101, 1, 1'b0, 1'b0);
    settle();
    checks += 3;
    if (vcnt != v0 + 1) begin errors++; $display("FAIL early_frame_count: frames=%0d expected %0d", vcnt, v0 + 1); end
    if (ecnt != e0 + 1) begin errors++; $display("FAIL early_err_count: errs=%0d expected %0d", ecnt, e0 + 1); end
    if (locked !== 1'b1) begin errors++; $display("FAIL early_locked_after: got %b expected 1", locked); end
    // Sync on the frame-closing slot aborts the frame instead of emitting it.
    put(1'b0, 1'b1);
    for (int i = 1; i < int'(NSLOT) - 1; i++) put(1'b1, 1'b0);
    put(1'b1, 1'b1);
    settle();
    checks += 2;
    if (sync_err !== 1'b1) begin errors++; $display("FAIL lastslot_sync_err: got %b expected 1", sync_err); end
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL lastslot_no_valid: got %b expected 0", dout_valid); end
    send_from(4'b0001, 1, 1'b0, 1'b0);
    settle();
    checks++;
    if (vcnt != v0 + 2) begin errors++; $display("FAIL lastslot_frame_count: frames=%0d expected %0d", vcnt, v0 + 2); end
  endtask

  task automatic test_missing_sync();
    int v0, e0;
    send_from(4'b1010, 0, 1'b0, 1'b0);
    v0 = vcnt + 1;
    put(1'b1, 1'b0);
    settle();
    checks += 2;
    if (sync_err !== 1'b1) begin errors++; $display("FAIL missing_sync_err: got %b expected 1", sync_err); end
    if (locked !== 1'b0) begin errors++; $display("FAIL missing_unlock: locked=%b expected 0", locked); end
    e0 = ecnt;
    for (int i = 0; i < 6; i++) put(W'($urandom), 1'b0);
    settle();
    checks += 3;
    if (locked !== 1'b0) begin errors++; $display("FAIL hunt_stays: locked=%b expected 0", locked); end
    if (vcnt != v0) begin errors++; $display("FAIL hunt_no_frame: frames=%0d expected %0d", vcnt, v0); end
    if (ecnt != e0) begin errors++; $display("FAIL hunt_no_err: errs=%0d expected %0d", ecnt, e0); end
    send_from(4'b0111, 0, 1'b0, 1'b0);
    settle();
    checks++;
    if (vcnt != v0 + 1) begin errors++; $display("FAIL relock_frame: frames=%0d expected %0d", vcnt, v0 + 1); end
  endtask

  task automatic test_back_to_back();
    logic [4*W-1:0] f;
    vtimes.delete();
    for (int k = 0; k < 4; k++) begin
      f = (4*W)'($urandom);
      send_from(f, 0, 1'b0, 1'b0);
    end
    settle();
    checks++;
    if (vtimes.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: frames=%0d expected 4", vtimes.size());
    end else begin
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (vtimes[k] - vtimes[k-1] != NSLOT * PERIOD) begin
          errors++;
          $display("FAIL b2b_spacing: gap=%0t expected %0d", vtimes[k] - vtimes[k-1], NSLOT * PERIOD);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    send_from(4'b1011, 0, 1'b0, 1'b0);
    put(1'b1, 1'b1);
    put(1'b0, 1'b0);
    put(1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    din_valid = 1'b0;
    #1;
    checks += 4;
    if (dout !== '0) begin errors++; $display("FAIL midrst_dout: got %h expected 0", dout); end
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", dout_valid); end
    if (locked !== 1'b0) begin errors++; $display("FAIL midrst_locked: got %b expected 0", locked); end
    if (sync_err !== 1'b0) begin errors++; $display("FAIL midrst_sync_err: got %b expected 0", sync_err); end
    @(negedge clk);
    rst_n = 1'b1;
    v0 = vcnt;
    for (int i = 0; i < int'(NSLOT); i++) put(1'b1, 1'b0);
    settle();
    checks += 2;
    if (locked !== 1'b0) begin errors++; $display("FAIL midrst_hunt: locked=%b expected 0", locked); end
    if (vcnt != v0) begin errors++; $display("FAIL midrst_no_frame: frames=%0d expected %0d", vcnt, v0); end
    send_from(4'b1001, 0, 1'b0, 1'b0);
    settle();
    checks++;
    if (vcnt != v0 + 1) begin errors++; $display("FAIL midrst_restart: frames=%0d expected %0d", vcnt, v0 + 1); end
  endtask

`ifdef TDM_PARITY_EN
  task automatic test_parity();
    int v0 = vcnt;
    send_from(4'b1101, 0, 1'b0, 1'b0);
    send_from(4'b1101, 0, 1'b0, 1'b1);
    settle();
    checks++;
    if (vcnt != v0 + 2) begin errors++; $display("FAIL parity_frames: frames=%0d expected %0d", vcnt, v0 + 2); end
  endtask
`endif

  initial begin
    test_reset();
    test_lock_frame();
    test_valid_gaps();
    test_early_sync();
    test_missing_sync();
    test_back_to_back();
    test_reset_mid();
`ifdef TDM_PARITY_EN
    test_parity();
`endif
    gap(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL frames_outstanding: %0d expected frames never appeared", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
